// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register-file writeback path.
//   RF_DATA_WIDTH / RF_ADDRESS_WIDTH / RF_NUM_REGS : defaults shared with the
//                                                    register file itself
//   MAX_REQ   : widest requester vector the rotate-priority helper handles
//   wbState_e : writeback arbiter FSM states
//   rrPick_t  : result of a rotate-priority search (found flag + index)
//   rrSearch  : rotate-priority search starting at a pointer, wrapping
//               modulo the live requester count
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int RF_DATA_WIDTH    = 32;
    localparam int RF_ADDRESS_WIDTH = 5;
    localparam int RF_NUM_REGS      = 32;
    localparam int MAX_REQ          = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } wbState_e;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rrPick_t;

    // Walk the request vector starting at ptr; the first set bit wins.
    // Only the first numReq positions take part, and because ptr is always
    // below numReq a single subtraction is enough to wrap the candidate.
    function automatic rrPick_t rrSearch(input logic [MAX_REQ-1:0] req,
                                         input logic [3:0]         numReq,
                                         input logic [2:0]         ptr);
        rrPick_t    pick;
        logic [3:0] cand;
        pick = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            cand = {1'b0, ptr} + 4'(k);
            if (cand >= numReq) begin
                cand = cand - numReq;
            end
            if ((4'(k) < numReq) && !pick.found && req[cand[2:0]]) begin
                pick.found = 1'b1;
                pick.idx   = cand[2:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter, reusable by any shared resource.
//   req        : request vector, one bit per requester
//   ptr        : index with the highest priority this cycle
//   grant      : one-hot grant, or zero when nothing is requested
//   grantIdx   : binary index of the granted requester
//   grantValid : 1 when some requester was granted
// ---------------------------------------------------------------------------
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grantIdx,
    output logic               grantValid
);

    logic [MAX_REQ-1:0] reqWide;
    logic [2:0]         ptrWide;
    rrPick_t            pick;
    logic               unusedIdxBits;

    // Widen the request vector and pointer to the helper's fixed width so
    // a single package function serves every requester count.
    always_comb begin
        reqWide                = '0;
        reqWide[NUM_REQ-1:0]   = req;
        ptrWide                = '0;
        ptrWide[PTR_W-1:0]     = ptr;
        pick                   = rrSearch(reqWide, 4'(NUM_REQ), ptrWide);
    end

    // Turn the search result into a one-hot grant plus its index.
    always_comb begin
        grant      = '0;
        grantValid = pick.found;
        grantIdx   = pick.idx[PTR_W-1:0];
        if (pick.found) begin
            grant[pick.idx[PTR_W-1:0]] = 1'b1;
        end
    end

    // Upper index bits are always zero for small requester counts.
    assign unusedIdxBits = ^pick.idx;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Owns the single register-file write port and shares it between NUM_REQ
// writeback requesters with valid/ready handshakes and round-robin priority.
// After reset it first clears registers 1..NUM_REGS-1 through the same port.
//   clk           : clock, all state updates on posedge
//   rst           : asynchronous active-low reset
//   stall         : 1 = grant nothing this cycle
//   req_valid     : per-requester write pending
//   req_ready     : one-hot or zero grant (combinational)
//   req_addr      : packed destination registers, requester i at [i*AW +: AW]
//   req_data      : packed write data, requester i at [i*DW +: DW]
//   RegWrite      : registered register-file write enable
//   WriteRegister : registered register-file write address
//   WriteData     : registered register-file write data
//   clear_busy    : 1 while the clear sequence is running
// ---------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH     = RF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH  = RF_ADDRESS_WIDTH,
    parameter int NUM_REGS       = RF_NUM_REGS,
    parameter int NUM_REQ        = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             stall,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    output logic                             RegWrite,
    output logic [ADDRESS_WIDTH-1:0]         WriteRegister,
    output logic [DATA_WIDTH-1:0]            WriteData,
    output logic                             clear_busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_CLR = ADDRESS_WIDTH'(NUM_REGS - 1);
    localparam wbState_e RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

    wbState_e                 state;
    wbState_e                 nextState;
    logic [ADDRESS_WIDTH-1:0] clrCnt;
    logic [ADDRESS_WIDTH-1:0] nextClrCnt;
    logic [PTR_W-1:0]         rrPtr;
    logic [PTR_W-1:0]         nextPtr;
    logic                     nextRegWrite;
    logic [ADDRESS_WIDTH-1:0] nextWriteRegister;
    logic [DATA_WIDTH-1:0]    nextWriteData;
    logic [NUM_REQ-1:0]       grant;
    logic [PTR_W-1:0]         grantIdx;
    logic                     grantValid;
    logic [ADDRESS_WIDTH-1:0] acceptAddr;
    logic [DATA_WIDTH-1:0]    acceptData;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) uArb (
        .req        (req_valid),
        .ptr        (rrPtr),
        .grant      (grant),
        .grantIdx   (grantIdx),
        .grantValid (grantValid)
    );

    assign acceptAddr = req_addr[grantIdx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign acceptData = req_data[grantIdx*DATA_WIDTH +: DATA_WIDTH];
    assign clear_busy = (state == CLEAR);

    // State, clear counter, priority pointer and the write-port registers.
    // Everything returns to its reset value the moment rst drops, so a clear
    // interrupted part-way restarts from register 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= RESET_STATE;
            clrCnt        <= ADDRESS_WIDTH'(1);
            rrPtr         <= '0;
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else begin
            state         <= nextState;
            clrCnt        <= nextClrCnt;
            rrPtr         <= nextPtr;
            RegWrite      <= nextRegWrite;
            WriteRegister <= nextWriteRegister;
            WriteData     <= nextWriteData;
        end
    end

    // Next-state and handshake logic. CLEAR walks the register addresses
    // with zero data and ignores requesters entirely. RUN forwards the
    // arbiter's grant unless stalled; an accepted write to x0 still
    // completes its handshake but leaves the write enable low. Without an
    // accept, address and data hold so the register file sees stable values.
    always_comb begin
        nextState         = state;
        nextClrCnt        = clrCnt;
        nextPtr           = rrPtr;
        nextRegWrite      = 1'b0;
        nextWriteRegister = WriteRegister;
        nextWriteData     = WriteData;
        req_ready         = '0;
        case (state)
            CLEAR: begin
                nextRegWrite      = 1'b1;
                nextWriteRegister = clrCnt;
                nextWriteData     = '0;
                nextClrCnt        = clrCnt + 1'b1;
                if (clrCnt == LAST_CLR) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                if (!stall && grantValid) begin
                    req_ready         = grant;
                    nextWriteRegister = acceptAddr;
                    nextWriteData     = acceptData;
                    nextRegWrite      = (acceptAddr != '0);
                    nextPtr           = (grantIdx == PTR_W'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
                end
            end
            default: begin
                nextState = RESET_STATE;
            end
        endcase
        if (!rst) begin
            req_ready = '0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Self-checking bench for regfile_wb_arbiter with two requesters. A simple
// register file model sits on the write port, and a reference model tracks
// the expected grant, write-port values and register contents.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;
    localparam int NREQ = 2;

    logic              clk;
    logic              rst;
    logic              stall;
    logic [NREQ-1:0]   reqValid;
    logic [NREQ-1:0]   reqReady;
    logic [NREQ*AW-1:0] reqAddr;
    logic [NREQ*DW-1:0] reqData;
    logic              regWrite;
    logic [AW-1:0]     writeRegister;
    logic [DW-1:0]     writeData;
    logic              clearBusy;

    logic [DW-1:0]     rfMem [NREG];

    logic [DW-1:0]     mRegs [NREG];
    int                mPtr;
    logic [AW-1:0]     mWReg;
    logic [DW-1:0]     mWData;
    int                acceptCount [NREQ];
    int                checkCount;
    int                passCount;
    int                acc;

    regfile_wb_arbiter #(
        .DATA_WIDTH     (DW),
        .ADDRESS_WIDTH  (AW),
        .NUM_REGS       (NREG),
        .NUM_REQ        (NREQ),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .req_valid     (reqValid),
        .req_ready     (reqReady),
        .req_addr      (reqAddr),
        .req_data      (reqData),
        .RegWrite      (regWrite),
        .WriteRegister (writeRegister),
        .WriteData     (writeData),
        .clear_busy    (clearBusy)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file on the write port: commits at the negedge inside the
    // cycle where the write enable is high, and powers up clear under reset.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) rfMem[i] <= '0;
        end else if (regWrite) begin
            rfMem[writeRegister] <= writeData;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic valid, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        reqValid[idx]          = valid;
        reqAddr[idx*AW +: AW]  = addr;
        reqData[idx*DW +: DW]  = data;
    endtask

    // One RUN cycle: predict the grant from the current inputs, check the
    // ready vector, clock it, then check the write port against the model.
    task automatic stepCycle(output int accIdx);
        int            idx;
        int            c;
        logic [NREQ-1:0] expReady;
        logic          expWe;
        #1;
        idx = -1;
        if (!stall) begin
            for (int k = 0; k < NREQ; k++) begin
                c = (mPtr + k) % NREQ;
                if (reqValid[c] && idx < 0) idx = c;
            end
        end
        expReady = '0;
        if (idx >= 0) expReady[idx] = 1'b1;
        checkOutput("req_ready", 64'(reqReady), 64'(expReady));
        expWe = 1'b0;
        if (idx >= 0) begin
            mWReg  = reqAddr[idx*AW +: AW];
            mWData = reqData[idx*DW +: DW];
            expWe  = (mWReg != 0);
            if (expWe) mRegs[mWReg] = mWData;
            mPtr = (idx + 1) % NREQ;
            acceptCount[idx]++;
        end
        @(posedge clk);
        #1;
        checkOutput("RegWrite", 64'(regWrite), 64'(expWe));
        checkOutput("WriteRegister", 64'(writeRegister), 64'(mWReg));
        checkOutput("WriteData", 64'(writeData), 64'(mWData));
        checkOutput("clear_busy_run", 64'(clearBusy), 64'(0));
        accIdx = idx;
    endtask

    // Clear sequence after reset release: register n is written at posedge n
    // and clear_busy stays high until the posedge that issues the last one.
    task automatic runClear(input int lastAddr);
        for (int n = 1; n <= lastAddr; n++) begin
            #1;
            checkOutput("clear_ready", 64'(reqReady), 64'(0));
            checkOutput("clear_busy_pre", 64'(clearBusy), 64'(1));
            @(posedge clk);
            #1;
            checkOutput("clear_we", 64'(regWrite), 64'(1));
            checkOutput("clear_addr", 64'(writeRegister), 64'(n));
            checkOutput("clear_data", 64'(writeData), 64'(0));
            checkOutput("clear_busy_post", 64'(clearBusy), 64'(n != NREG - 1));
        end
    endtask

    task automatic checkResetState();
        checkOutput("rst_we", 64'(regWrite), 64'(0));
        checkOutput("rst_addr", 64'(writeRegister), 64'(0));
        checkOutput("rst_data", 64'(writeData), 64'(0));
        checkOutput("rst_busy", 64'(clearBusy), 64'(1));
        checkOutput("rst_ready", 64'(reqReady), 64'(0));
    endtask

    task automatic modelAfterClear();
        for (int i = 0; i < NREG; i++) mRegs[i] = '0;
        mWReg  = AW'(NREG - 1);
        mWData = '0;
        mPtr   = 0;
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        rst        = 1'b0;
        stall      = 1'b0;
        reqValid   = '0;
        reqAddr    = '0;
        reqData    = '0;
        for (int i = 0; i < NREQ; i++) acceptCount[i] = 0;

        // Reset with both requesters already pending.
        applyStimulus(0, 1'b1, 5'd5, 32'hDEADBEEF);
        applyStimulus(1, 1'b1, 5'd6, 32'h12345678);
        repeat (3) @(posedge clk);
        #1;
        checkResetState();
        rst = 1'b1;

        // Full clear, requesters held off throughout.
        runClear(NREG - 1);
        modelAfterClear();

        // Both valid after clear: req0 then req1.
        stepCycle(acc);
        checkOutput("first_grant", 64'(acc), 64'(0));
        reqValid[0] = 1'b0;
        stepCycle(acc);
        checkOutput("second_grant", 64'(acc), 64'(1));
        reqValid[1] = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rf_x5", 64'(rfMem[5]), 64'h0000_0000_DEAD_BEEF);
        checkOutput("rf_x6", 64'(rfMem[6]), 64'h0000_0000_1234_5678);

        // Fairness: both held valid for 8 cycles alternate 0,1,0,1...
        for (int i = 0; i < NREQ; i++) acceptCount[i] = 0;
        applyStimulus(0, 1'b1, 5'd7, $urandom);
        applyStimulus(1, 1'b1, 5'd8, $urandom);
        for (int k = 0; k < 8; k++) begin
            stepCycle(acc);
            checkOutput("alternate", 64'(acc), 64'(k % 2));
            if (acc >= 0) reqData[acc*DW +: DW] = $urandom;
        end
        checkOutput("fair_count0", 64'(acceptCount[0]), 64'(4));
        checkOutput("fair_count1", 64'(acceptCount[1]), 64'(4));
        reqValid = '0;

        // Write to x0 completes its handshake but is suppressed.
        applyStimulus(1, 1'b1, 5'd0, 32'hFFFFFFFF);
        stepCycle(acc);
        checkOutput("x0_grant", 64'(acc), 64'(1));
        reqValid = '0;
        @(negedge clk);
        #1;
        checkOutput("rf_x0", 64'(rfMem[0]), 64'(0));

        // Stall for 3 cycles with both pending; pointer must not move.
        stall = 1'b1;
        applyStimulus(0, 1'b1, 5'd9, 32'hA5A5_0009);
        applyStimulus(1, 1'b1, 5'd10, 32'h5A5A_000A);
        repeat (3) begin
            stepCycle(acc);
            checkOutput("stall_nogrant", 64'(acc + 1), 64'(0));
        end
        stall = 1'b0;
        stepCycle(acc);
        checkOutput("post_stall_grant", 64'(acc), 64'(0));
        reqValid[0] = 1'b0;
        stepCycle(acc);
        checkOutput("post_stall_grant1", 64'(acc), 64'(1));
        reqValid = '0;

        // Random traffic with held requests and random stalls.
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!reqValid[i] && $urandom_range(0, 99) < 60) begin
                    applyStimulus(i, 1'b1, AW'($urandom_range(0, NREG - 1)), $urandom);
                end
            end
            stall = ($urandom_range(0, 3) == 0);
            stepCycle(acc);
            if (acc >= 0) reqValid[acc] = 1'b0;
        end
        stall    = 1'b0;
        reqValid = '0;
        @(negedge clk);
        #1;
        for (int r = 0; r < NREG; r++) begin
            checkOutput($sformatf("rf_final[%0d]", r), 64'(rfMem[r]), 64'(mRegs[r]));
        end

        // Reset mid-clear at address 10, then the full clear again.
        reqValid = 2'b11;
        rst = 1'b0;
        #1;
        checkResetState();
        @(posedge clk);
        #1;
        rst = 1'b1;
        runClear(10);
        rst = 1'b0;
        #1;
        checkResetState();
        @(posedge clk);
        #1;
        rst = 1'b1;
        runClear(NREG - 1);
        modelAfterClear();
        stepCycle(acc);
        checkOutput("after_reclear_grant", 64'(acc), 64'(0));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
